// File: rtl/freq_ctl_pkg.sv
// Shared types and constants for the front-panel frequency controller.
package freq_ctl_pkg;

  typedef logic [11:0] freq_word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } dir_state_e;

  typedef enum logic [1:0] {
    STEP_1    = 2'd0,
    STEP_10   = 2'd1,
    STEP_100  = 2'd2,
    STEP_1000 = 2'd3
  } step_sel_e;

  localparam freq_word_t STEP_VAL [4] = '{12'd1, 12'd10, 12'd100, 12'd1000};

  function automatic freq_word_t step_value(input logic [1:0] sel);
    return STEP_VAL[sel];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push-button.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // sync_p0/sync_p1 are the metastability stages; level only moves after
  // sync_p1 has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_p1;
        rise  <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_ctl_ctrl.sv
// Front-panel controller stepping the DDS frequency word with debounced keys.
// Hold-to-repeat is built only when FREQ_CTL_REPEAT_EN is defined.
module freq_ctl_ctrl
  import freq_ctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000,
  parameter int FREQ_MIN        = 1,
  parameter int FREQ_MAX        = 4095,
  parameter int FREQ_RESET      = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_step,
  output logic [11:0] freq_ctl,
  output logic [1:0]  step_sel,
  output logic        update
);

  function automatic freq_word_t sat_up(input freq_word_t f, input freq_word_t s);
    logic [12:0] sum;
    sum = {1'b0, f} + {1'b0, s};
    if (sum > 13'(FREQ_MAX)) return freq_word_t'(FREQ_MAX);
    return sum[11:0];
  endfunction

  // Compare before subtracting so the result never wraps below zero.
  function automatic freq_word_t sat_down(input freq_word_t f, input freq_word_t s);
    if ({1'b0, f} < 13'(FREQ_MIN) + {1'b0, s}) return freq_word_t'(FREQ_MIN);
    return f - s;
  endfunction

  logic up_lvl, up_rise;
  logic dn_lvl, dn_rise;
  logic st_rise;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clk  (clk),
    .rst  (rst),
    .key  (key_up),
    .level(up_lvl),
    .rise (up_rise)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
    .clk  (clk),
    .rst  (rst),
    .key  (key_down),
    .level(dn_lvl),
    .rise (dn_rise)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
    .clk  (clk),
    .rst  (rst),
    .key  (key_step),
    .level(),
    .rise (st_rise)
  );

  dir_state_e state, state_next;
  logic       dir_up, dir_up_next;
  logic       apply, apply_up;
  logic       both, dir_lvl;
  freq_word_t freq_next;

  assign both    = up_lvl & dn_lvl;
  assign dir_lvl = dir_up ? up_lvl : dn_lvl;

`ifdef FREQ_CTL_REPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

  logic [TMR_W-1:0] timer;
  logic             timer_clr;

  always_ff @(posedge clk) begin
    if (rst || timer_clr) timer <= '0;
    else                  timer <= timer + 1'b1;
  end
`endif

  always_comb begin
    state_next  = state;
    dir_up_next = dir_up;
    apply       = 1'b0;
    apply_up    = dir_up;
`ifdef FREQ_CTL_REPEAT_EN
    timer_clr   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
`ifdef FREQ_CTL_REPEAT_EN
        timer_clr = 1'b1;
`endif
        // A rise with the other key already down is a both-pressed case.
        if (!both && (up_rise || dn_rise)) begin
          apply       = 1'b1;
          apply_up    = up_rise;
          dir_up_next = up_rise;
          state_next  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (both || !dir_lvl) begin
          state_next = ST_IDLE;
`ifdef FREQ_CTL_REPEAT_EN
        end else if (timer == TMR_W'(REPEAT_DELAY - 1)) begin
          apply      = 1'b1;
          timer_clr  = 1'b1;
          state_next = ST_REPEAT;
`endif
        end
      end
`ifdef FREQ_CTL_REPEAT_EN
      ST_REPEAT: begin
        if (both || !dir_lvl) begin
          state_next = ST_IDLE;
        end else if (timer == TMR_W'(REPEAT_RATE - 1)) begin
          apply     = 1'b1;
          timer_clr = 1'b1;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    freq_next = freq_ctl;
    if (apply_up) freq_next = sat_up(freq_ctl, step_value(step_sel));
    else          freq_next = sat_down(freq_ctl, step_value(step_sel));
  end

  // Registered outputs: word, step selection and change strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir_up   <= 1'b0;
      freq_ctl <= freq_word_t'(FREQ_RESET);
      step_sel <= STEP_1;
      update   <= 1'b0;
    end else begin
      state    <= state_next;
      dir_up   <= dir_up_next;
      update   <= apply && (freq_next != freq_ctl);
      if (apply) freq_ctl <= freq_next;
      if (st_rise) step_sel <= step_sel + 2'd1;
    end
  end

endmodule

// File: tb/tb_freq_ctl_ctrl.sv
// Directed and randomized bench for freq_ctl_ctrl with a press-level reference model.
module tb_freq_ctl_ctrl;

  localparam int DEB  = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;
  localparam int FMIN = 1;
  localparam int FMAX = 4095;
  localparam int FRST = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_up;
  logic        key_down;
  logic        key_step;
  logic [11:0] freq_ctl;
  logic [1:0]  step_sel;
  logic        update;

  int checks  = 0;
  int errors  = 0;
  int upd_cnt = 0;
  int m_freq;
  int m_sel;
  int m_upd;

  freq_ctl_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .FREQ_MIN       (FMIN),
    .FREQ_MAX       (FMAX),
    .FREQ_RESET     (FRST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_up  (key_up),
    .key_down(key_down),
    .key_step(key_step),
    .freq_ctl(freq_ctl),
    .step_sel(step_sel),
    .update  (update)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return 10;
      2:       return 100;
      default: return 1000;
    endcase
  endfunction

  // Key held for h cycles: first step 2+DEB+1 cycles after press, the
  // debounced level stays high until 2+DEB cycles after release.
  function automatic int n_steps(input int h);
    int n;
    n = 1;
`ifdef FREQ_CTL_REPEAT_EN
    if (h - 1 >= RD) n = 2 + (h - 1 - RD) / RR;
`endif
    return n;
  endfunction

  task automatic model_step(input bit up);
    int nf;
    nf = up ? m_freq + step_of(m_sel) : m_freq - step_of(m_sel);
    if (nf > FMAX) nf = FMAX;
    if (nf < FMIN) nf = FMIN;
    if (nf != m_freq) m_upd++;
    m_freq = nf;
  endtask

  task automatic press(input bit u, input bit d, input bit s, input int h);
    key_up = u; key_down = d; key_step = s;
    tick(h);
    key_up = 1'b0; key_down = 1'b0; key_step = 1'b0;
    tick(12);
  endtask

  task automatic do_up(input int h);
    press(1'b1, 1'b0, 1'b0, h);
    for (int i = 0; i < n_steps(h); i++) model_step(1'b1);
  endtask

  task automatic do_down(input int h);
    press(1'b0, 1'b1, 1'b0, h);
    for (int i = 0; i < n_steps(h); i++) model_step(1'b0);
  endtask

  task automatic do_step();
    press(1'b0, 1'b0, 1'b1, 6);
    m_sel = (m_sel + 1) % 4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_freq = FRST;
    m_sel  = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".freq"}, freq_ctl, m_freq);
    chk({tag, ".sel"}, step_sel, m_sel);
    chk({tag, ".upd_count"}, upd_cnt, m_upd);
    chk({tag, ".upd_idle"}, update, 0);
  endtask

  initial begin
    rst = 1'b1; key_up = 1'b0; key_down = 1'b0; key_step = 1'b0;
    m_freq = FRST; m_sel = 0; m_upd = 0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_state("reset");

    // Bouncy up press: 1,0,1,0 then stable high.
    key_up = 1'b1; tick(1);
    key_up = 1'b0; tick(1);
    key_up = 1'b1; tick(1);
    key_up = 1'b0; tick(1);
    key_up = 1'b1;
    tick(6);
    chk("latency.before", freq_ctl, FRST);
    chk("latency.upd_before", update, 0);
    tick(1);
    chk("latency.at", freq_ctl, FRST + 1);
    chk("latency.upd_at", update, 1);
    tick(1);
    chk("latency.upd_width", update, 0);
    key_up = 1'b0;
    tick(12);
    model_step(1'b1);
    check_state("bounce_up");

    // Low clamp with the 1000 step.
    do_reset();
    do_step(); do_step(); do_step();
    check_state("sel3");
    do_down(6);
    check_state("down_clamp");
    do_down(6);
    check_state("down_at_min");

    // High clamp: 4000 + 100 -> 4095.
    do_reset();
    do_step(); do_step(); do_step();
    do_up(6); do_up(6); do_up(6);
    check_state("reach_4000");
    do_step(); do_step(); do_step();
    do_up(6);
    check_state("up_clamp");
    do_up(6);
    check_state("up_at_max");

    // Long hold: one step, or five with auto-repeat.
    do_reset();
    do_up(40);
    check_state("hold_up40");
    do_down(33);
    check_state("hold_down33");

    // Both keys together never step.
    press(1'b1, 1'b1, 1'b0, 30);
    check_state("both_held");

    // Reset mid-hold, key kept down through reset release.
    do_reset();
    key_up = 1'b1;
    tick(30);
    for (int i = 0; i < n_steps(30); i++) model_step(1'b1);
    rst = 1'b1;
    tick(1);
    m_freq = FRST; m_sel = 0;
    chk("rst_hold.freq", freq_ctl, FRST);
    chk("rst_hold.sel", step_sel, 0);
    chk("rst_hold.upd", update, 0);
    rst = 1'b0;
    tick(6);
    chk("rst_hold.no_step_yet", freq_ctl, FRST);
    tick(1);
    chk("rst_hold.new_press", freq_ctl, FRST + 1);
    key_up = 1'b0;
    tick(12);
    model_step(1'b1);
    check_state("rst_hold.after");

    // Random mix of step-key, up and down presses.
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 2))
        0:       do_step();
        1:       do_up($urandom_range(6, 45));
        default: do_down($urandom_range(6, 45));
      endcase
      check_state($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_ctl_ctrl.md
# freq_ctl_ctrl

Front-panel controller that owns the DDS frequency control word. It debounces three push-buttons (up, down, step) and steps `freq_ctl` by a selectable decade (1/10/100/1000), saturating at programmable limits, with optional hold-to-repeat. `freq_ctl` drives the phase-accumulator increment and the BCD display converter; `update` tells downstream logic that a new word is live.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles before a key's debounced level changes (10 ms at 100 MHz).
- `REPEAT_DELAY`, 50_000_000: cycles a key is held before auto-repeat starts.
- `REPEAT_RATE`, 10_000_000: cycles between repeated steps.
- `FREQ_MIN`, 1: lower clamp of `freq_ctl`.
- `FREQ_MAX`, 4095: upper clamp of `freq_ctl`.
- `FREQ_RESET`, 1000: value of `freq_ctl` after reset.
- `clk`  in  1  system clock; only clock.
- `rst`  in  1  synchronous, active-high reset.
- `key_up`  in  1  raw button, active-high, asynchronous to `clk`.
- `key_down`  in  1  raw button, active-high, asynchronous.
- `key_step`  in  1  raw button, active-high, asynchronous; cycles step size.
- `freq_ctl`  out  12  frequency control word, registered.
- `step_sel`  out  2  0=1, 1=10, 2=100, 3=1000.
- `update`  out  1  one-cycle pulse when `freq_ctl` changed value.

## Operation
- Each key: 2-flop synchronizer, then debounce counter; debounced level flips only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles; any bounce clears the counter.
- Step key: on debounced rising edge, `step_sel` increments mod 4 (3 -> 0). No effect on `freq_ctl`.
- Direction FSM, states IDLE, HOLD, REPEAT:
  - IDLE: debounced rising edge of exactly one of up/down -> apply one step, latch direction, clear timer, go HOLD.
  - HOLD: key released -> IDLE; timer reaches `REPEAT_DELAY` -> apply step, clear timer, go REPEAT.
  - REPEAT: key released -> IDLE; timer reaches `REPEAT_RATE` -> apply step, clear timer.
  - Both up and down debounced high in any state -> no step, go IDLE; a new step needs a fresh single-key rising edge.
- Arithmetic: 13-bit intermediate. Up: `min(freq_ctl + step, FREQ_MAX)`. Down: `max(freq_ctl - step, FREQ_MIN)`, computed without underflow (if `freq_ctl < FREQ_MIN + step` result is `FREQ_MIN`).
- `update` asserts only if the new value differs from the old; a step at a clamp leaves `update` low.
- Step change while holding up/down: next repeat uses the new `step_sel`.

## Timing
- Reset (`rst` sampled high): `freq_ctl`=`FREQ_RESET`, `step_sel`=0, `update`=0, FSM IDLE, timers 0, synchronizers and debounced levels 0. Applies mid-hold; a key held across reset release is treated as a new press after `DEBOUNCE_CYCLES`.
- Latency: `freq_ctl` and `update` change on the edge after the cycle in which the debounced level rises (raw key to `freq_ctl`: 2 sync + `DEBOUNCE_CYCLES` + 1 cycles).
- `step_sel` updates on the edge after the debounced step-key rise.
- Repeat steps: first at `REPEAT_DELAY` cycles after the initial step, then every `REPEAT_RATE` cycles.
- `update` is exactly one cycle wide; back-to-back steps produce separate pulses.

## Configuration
- `FREQ_CTL_REPEAT_EN` defined: HOLD/REPEAT behaviour as above.
- Not defined: no repeat timer logic; FSM is IDLE/HOLD only, one step per press, HOLD waits for release (or both-pressed) then IDLE.

## Structure
- Shared package `freq_ctl_pkg`: FSM state enum, `step_sel` encoding, step-value constant array {1,10,100,1000}, 12-bit word typedef.
- Sub-module `key_debounce` (synchronizer + counter, parameter `DEBOUNCE_CYCLES`, outputs level and rising-edge pulse), instantiated three times.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=5.
- Reset, no keys -> `freq_ctl`=1000, `step_sel`=0, `update`=0.
- Up press, 3-cycle bounce then stable -> exactly one step to 1001, single `update` pulse at 2+4+1 cycles after stable.
- Step key 3x, then down -> `step_sel`=3, `freq_ctl` 1000 -> 1 (clamped, 1000-1000=0<1); second down -> stays 1, no `update`.
- `freq_ctl`=4000, step 100, up -> 4095; up again -> 4095, `update` low.
- Up held 40 cycles, repeat enabled -> steps at t0, t0+20, t0+25, t0+30, t0+35; disabled -> single step.
- Up and down both held -> no change; `rst` pulsed during REPEAT -> `freq_ctl`=1000, FSM IDLE.
